calculate_ntlm_reg: RTL and testbench

//  Iterative NTLM (MD4 over UTF-16LE password) hash-check engine for the password-cracker datapath.

---
 rtl/calculate_ntlm_reg.sv | 194 +++++++++++++++++++
 tb/tb_calculate_ntlm_reg.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/calculate_ntlm_reg.sv
`default_nettype none
// ============================================================================
// Module      : calculate_ntlm_reg
// Description : Iterative NTLM hash-check engine. The engine captures a
//               candidate ASCII password and a target NTLM digest. It then
//               runs MD4 over the UTF-16LE form of the password, one step
//               per clock. On a digest match it publishes the captured
//               candidate on outstr. On a mismatch it publishes zero.
//               The engine runs continuously with a fixed 50-cycle period:
//               LOAD (1) + ROUND (48) + FINAL (1).
// Ports       : clk    - system clock, rising edge
//               n_rst  - asynchronous active-low reset
//               instr  - candidate password, char 0 in instr[127:120]
//               length - number of valid chars (0..15)
//               hash   - target digest, first digest byte in hash[127:120]
//               outstr - captured instr on match, else zero (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module calculate_ntlm_reg (
    input  logic         clk,
    input  logic         n_rst,
    input  logic [127:0] instr,
    input  logic [3:0]   length,
    input  logic [127:0] hash,
    output logic [127:0] outstr
);

    localparam logic [1:0]  S_LOAD  = 2'd0;
    localparam logic [1:0]  S_ROUND = 2'd1;
    localparam logic [1:0]  S_FINAL = 2'd2;

    localparam logic [31:0] C_IV_A  = 32'h67452301;
    localparam logic [31:0] C_IV_B  = 32'hefcdab89;
    localparam logic [31:0] C_IV_C  = 32'h98badcfe;
    localparam logic [31:0] C_IV_D  = 32'h10325476;
    localparam logic [31:0] C_K1    = 32'h5a827999;
    localparam logic [31:0] C_K2    = 32'h6ed9eba1;
    localparam logic [5:0]  C_LAST  = 6'd47;

    logic [1:0]   r_state;
    logic [5:0]   r_step;
    logic [31:0]  r_a, r_b, r_c, r_d;
    logic [31:0]  r_m [16];
    logic [127:0] r_instr;
    logic [127:0] r_hash;
    logic [127:0] r_outstr;
    logic         r_match;

    // ------------------------------------------------------------------
    // Message block build from the live inputs; only consumed in LOAD.
    // Each char becomes a UTF-16LE code unit (char, 0x00). The 0x80 pad
    // byte follows the last code unit. The bit count (16*length, at most
    // 240) fits entirely in byte 56.
    // ------------------------------------------------------------------
    logic [7:0]  w_bytes [64];
    logic [31:0] w_blk   [16];

    always_comb begin
        for (int b = 0; b < 64; b++) begin
            w_bytes[b] = 8'h00;
        end
        for (int i = 0; i < 15; i++) begin
            if (4'(i) < length) begin
                w_bytes[2*i] = instr[127-8*i -: 8];
            end
        end
        w_bytes[{1'b0, length, 1'b0}] = 8'h80;
        w_bytes[56] = {length, 4'b0000};
        for (int j = 0; j < 16; j++) begin
            w_blk[j] = {w_bytes[4*j+3], w_bytes[4*j+2], w_bytes[4*j+1], w_bytes[4*j]};
        end
    end

    // ------------------------------------------------------------------
    // One MD4 step. The round is step[5:4] and the position within the
    // round is step[3:0]. The round-2 word order is a 2-bit rotate of the
    // position. The round-3 word order is the bit reversal of the position.
    // ------------------------------------------------------------------
    logic [3:0]  w_i, w_k;
    logic [4:0]  w_s;
    logic [31:0] w_f, w_kc, w_sum, w_t;

    always_comb begin
        w_i  = r_step[3:0];
        w_k  = w_i;
        w_kc = 32'h0;
        w_f  = (r_b & r_c) | (~r_b & r_d);
        case (w_i[1:0])
            2'd0:    w_s = 5'd3;
            2'd1:    w_s = 5'd7;
            2'd2:    w_s = 5'd11;
            default: w_s = 5'd19;
        endcase
        case (r_step[5:4])
            2'd1: begin
                w_f  = (r_b & r_c) | (r_b & r_d) | (r_c & r_d);
                w_kc = C_K1;
                w_k  = {w_i[1:0], w_i[3:2]};
                case (w_i[1:0])
                    2'd0:    w_s = 5'd3;
                    2'd1:    w_s = 5'd5;
                    2'd2:    w_s = 5'd9;
                    default: w_s = 5'd13;
                endcase
            end
            2'd2: begin
                w_f  = r_b ^ r_c ^ r_d;
                w_kc = C_K2;
                w_k  = {w_i[0], w_i[1], w_i[2], w_i[3]};
                case (w_i[1:0])
                    2'd0:    w_s = 5'd3;
                    2'd1:    w_s = 5'd9;
                    2'd2:    w_s = 5'd11;
                    default: w_s = 5'd15;
                endcase
            end
            default: ;
        endcase
        w_sum = r_a + w_f + r_m[w_k] + w_kc;
        // The shift amount is never zero, so (32 - s) never reaches 32.
        w_t   = (w_sum << w_s) | (w_sum >> (6'd32 - {1'b0, w_s}));
    end

    // Final digest, each word emitted low byte first.
    logic [31:0]  w_fa, w_fb, w_fc, w_fd;
    logic [127:0] w_digest;

    assign w_fa     = r_a + C_IV_A;
    assign w_fb     = r_b + C_IV_B;
    assign w_fc     = r_c + C_IV_C;
    assign w_fd     = r_d + C_IV_D;
    assign w_digest = {w_fa[7:0], w_fa[15:8], w_fa[23:16], w_fa[31:24],
                       w_fb[7:0], w_fb[15:8], w_fb[23:16], w_fb[31:24],
                       w_fc[7:0], w_fc[15:8], w_fc[23:16], w_fc[31:24],
                       w_fd[7:0], w_fd[15:8], w_fd[23:16], w_fd[31:24]};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state  <= S_LOAD;
            r_step   <= 6'd0;
            r_a      <= 32'h0;
            r_b      <= 32'h0;
            r_c      <= 32'h0;
            r_d      <= 32'h0;
            r_instr  <= 128'h0;
            r_hash   <= 128'h0;
            r_outstr <= 128'h0;
            r_match  <= 1'b0;
            for (int j = 0; j < 16; j++) begin
                r_m[j] <= 32'h0;
            end
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_instr <= instr;
                    r_hash  <= hash;
                    for (int j = 0; j < 16; j++) begin
                        r_m[j] <= w_blk[j];
                    end
                    r_a     <= C_IV_A;
                    r_b     <= C_IV_B;
                    r_c     <= C_IV_C;
                    r_d     <= C_IV_D;
                    r_step  <= 6'd0;
                    r_state <= S_ROUND;
                end
                S_ROUND: begin
                    r_a <= r_d;
                    r_b <= w_t;
                    r_c <= r_b;
                    r_d <= r_c;
                    if (r_step == C_LAST) begin
                        r_step  <= 6'd0;
                        r_state <= S_FINAL;
                    end else begin
                        r_step  <= r_step + 6'd1;
                    end
                end
                S_FINAL: begin
                    r_match  <= (w_digest == r_hash);
                    r_outstr <= (w_digest == r_hash) ? r_instr : 128'h0;
                    r_state  <= S_LOAD;
                end
                default: begin
                    r_state <= S_LOAD;
                end
            endcase
        end
    end

    assign outstr = r_outstr;

endmodule
`default_nettype wire

// File: tb/tb_calculate_ntlm_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_calculate_ntlm_reg
// Description : Self-checking bench for calculate_ntlm_reg. It runs a table
//               of directed vectors with known NTLM digests, then three
//               hand-written multi-cycle sequences: result stability, input
//               changes during ROUND, and a reset pulse during ROUND.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calculate_ntlm_reg;

    localparam logic [127:0] C_PW     = 128'h70617373776f72640000000000000000;
    localparam logic [127:0] C_PWXYZ  = 128'h70617373776f726458595a0000000000;
    localparam logic [127:0] C_BA     = 128'h62610000000000000000000000000000;
    localparam logic [127:0] C_ABC    = 128'h61626300000000000000000000000000;
    localparam logic [127:0] C_H_PW   = 128'h8846f7eaee8fb117ad06bdd830b7586c;
    localparam logic [127:0] C_H_PW1  = 128'h8846f7eaee8fb117ad06bdd830b7586d;
    localparam logic [127:0] C_H_EMP  = 128'h31d6cfe0d16ae931b73c59d7e0c089c0;

    logic         clk;
    logic         n_rst;
    logic [127:0] instr;
    logic [3:0]   length;
    logic [127:0] hash;
    logic [127:0] outstr;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [127:0] instr;
        logic [3:0]   len;
        logic [127:0] hash;
        logic [127:0] exp_out;
        logic         exp_match;
    } vec_t;

    vec_t vecs [8];

    calculate_ntlm_reg dut (
        .clk    (clk),
        .n_rst  (n_rst),
        .instr  (instr),
        .length (length),
        .hash   (hash),
        .outstr (outstr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0b expected=%0b", name, act, exp);
        end
    endtask

    // Reset is held across two edges. The inputs are applied and the reset
    // is released just after an edge, so the next edge is the first LOAD.
    task automatic start(input logic [127:0] s, input logic [3:0] l, input logic [127:0] h);
        n_rst = 1'b0;
        tick(2);
        instr  = s;
        length = l;
        hash   = h;
        n_rst  = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        n_rst    = 1'b0;
        instr    = 128'h0;
        length   = 4'd0;
        hash     = 128'h0;

        vecs[0] = '{C_PW,    4'd8,  C_H_PW,  C_PW,    1'b1};
        vecs[1] = '{128'h0,  4'd0,  C_H_EMP, 128'h0,  1'b1};
        vecs[2] = '{C_BA,    4'd2,  C_H_PW,  128'h0,  1'b0};
        vecs[3] = '{C_PWXYZ, 4'd8,  C_H_PW,  C_PWXYZ, 1'b1};
        vecs[4] = '{C_ABC,   4'd0,  C_H_EMP, C_ABC,   1'b1};
        vecs[5] = '{C_PW,    4'd8,  C_H_PW1, 128'h0,  1'b0};
        vecs[6] = '{C_PW,    4'd7,  C_H_PW,  128'h0,  1'b0};
        vecs[7] = '{C_PWXYZ, 4'd11, C_H_PW,  128'h0,  1'b0};

        tick(1);
        check128("reset_outstr", outstr, 128'h0);
        check1("reset_match", dut.r_match, 1'b0);

        for (int v = 0; v < 8; v++) begin
            start(vecs[v].instr, vecs[v].len, vecs[v].hash);
            tick(49);
            check128($sformatf("vec%0d_before_final", v), outstr, 128'h0);
            tick(1);
            check128($sformatf("vec%0d_result", v), outstr, vecs[v].exp_out);
            check1($sformatf("vec%0d_match", v), dut.r_match, vecs[v].exp_match);
        end

        // The result holds through the whole next period and is then rewritten.
        start(C_PW, 4'd8, C_H_PW);
        tick(50);
        check128("stable_first", outstr, C_PW);
        tick(49);
        check128("stable_hold", outstr, C_PW);
        tick(1);
        check128("stable_second", outstr, C_PW);

        // Inputs changed during ROUND must not affect the running check.
        // The next LOAD picks them up.
        start(C_PW, 4'd8, C_H_PW);
        tick(10);
        instr  = C_BA;
        length = 4'd2;
        hash   = C_H_EMP;
        tick(40);
        check128("midround_change_result", outstr, C_PW);
        tick(50);
        check128("midround_change_next", outstr, 128'h0);

        // A reset pulse during ROUND clears the output at once and restarts
        // the engine from LOAD.
        start(C_PW, 4'd8, C_H_PW);
        tick(50);
        check128("rstpulse_pre", outstr, C_PW);
        tick(20);
        n_rst = 1'b0;
        #1;
        check128("rstpulse_async_clear", outstr, 128'h0);
        tick(1);
        check128("rstpulse_held", outstr, 128'h0);
        n_rst = 1'b1;
        tick(49);
        check128("rstpulse_before_final", outstr, 128'h0);
        tick(1);
        check128("rstpulse_restart_result", outstr, C_PW);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
